// File: rtl/beep_sequencer_pkg.sv
// Shared encodings for the beep sequencer: pattern codes, FSM states and
// the number of tones each finite pattern plays.
package beep_sequencer_pkg;

    typedef enum logic [2:0] {
        PAT_NONE  = 3'd0,
        PAT_CLICK = 3'd1,
        PAT_PHASE = 3'd2,
        PAT_DONE  = 3'd3,
        PAT_ALARM = 3'd4
    } pat_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2,
        ST_SEP  = 2'd3
    } state_e;

    // Alarm has no tone count: it loops for as long as the alarm level is high.
    function automatic logic [1:0] tone_count(pat_e p);
        case (p)
            PAT_CLICK: return 2'd1;
            PAT_PHASE: return 2'd2;
            PAT_DONE:  return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/beep_sequencer_tick_divider.sv
// Prescaler: one-cycle tick every TICK_DIV cycles, realigned by restart so
// that every tone/gap segment starts on a fresh time unit.
module beep_sequencer_tick_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic cp,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = (restart || tick) ? '0 : cnt_q + PW'(1);
    end

    always_ff @(posedge cp) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/beep_sequencer.sv
// Plays timed buzzer patterns for controller events with alarm > done > phase
// > click priority, preemption and one pending bit each for phase and done.
module beep_sequencer
    import beep_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int SHORT_U  = 80,
    parameter int LONG_U   = 400,
    parameter int GAP_U    = 120,
    parameter int ALARM_U  = 250
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       ev_click,
    input  logic       ev_phase,
    input  logic       ev_done,
    input  logic       alarm,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [2:0] pattern
);

    localparam int UMAX = max4(SHORT_U, LONG_U, GAP_U, ALARM_U);
    localparam int UW   = (UMAX > 1) ? $clog2(UMAX) : 1;
    localparam logic [UW-1:0] SHORT_L = UW'(SHORT_U - 1);
    localparam logic [UW-1:0] LONG_L  = UW'(LONG_U - 1);
    localparam logic [UW-1:0] GAP_L   = UW'(GAP_U - 1);
    localparam logic [UW-1:0] ALARM_L = UW'(ALARM_U - 1);

    state_e        state_q, state_d;
    pat_e          pat_q, pat_d, req;
    logic [1:0]    pend_q, pend_d;    // {done, phase}
    logic [1:0]    tones_q, tones_d;  // tones still to play after the current one
    logic [UW-1:0] unit_q, unit_d, lim;
    logic          beep_q, beep_d;
    logic          tick, restart, alarm_req, preempt, seg_end, fin;
    logic [1:0]    arrive;

    beep_sequencer_tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .cp      (cp),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        case (state_q)
            ST_TONE: lim = (pat_q == PAT_ALARM) ? ALARM_L :
                           (pat_q == PAT_DONE)  ? LONG_L  : SHORT_L;
            ST_GAP:  lim = (pat_q == PAT_ALARM) ? ALARM_L : GAP_L;
            default: lim = GAP_L;
        endcase
    end

    always_comb begin
        alarm_req = alarm && (pat_q != PAT_ALARM);
        if (alarm_req)     req = PAT_ALARM;
        else if (ev_done)  req = PAT_DONE;
        else if (ev_phase) req = PAT_PHASE;
        else if (ev_click) req = PAT_CLICK;
        else               req = PAT_NONE;

        // During SEP nothing plays, so only the alarm may jump the queue;
        // click can only win from IDLE since it is dropped whenever busy.
        preempt = (req > pat_q) && ((state_q != ST_SEP) || alarm_req);
        arrive  = {ev_done  && !(preempt && req == PAT_DONE),
                   ev_phase && !(preempt && req == PAT_PHASE)};
        pend_d  = pend_q | arrive;
        seg_end = tick && (unit_q == lim);

        state_d = state_q;
        pat_d   = pat_q;
        tones_d = tones_q;
        unit_d  = unit_q;
        restart = 1'b0;
        fin     = 1'b0;

        if (preempt) begin
            state_d = ST_TONE;
            pat_d   = req;
            tones_d = tone_count(req) - 2'd1;
            unit_d  = '0;
            restart = 1'b1;
        end else begin
            case (state_q)
                ST_TONE, ST_GAP: begin
                    if (pat_q == PAT_ALARM && !alarm) begin
                        fin = 1'b1;
                    end else if (seg_end) begin
                        restart = 1'b1;
                        unit_d  = '0;
                        if (state_q == ST_GAP) begin
                            state_d = ST_TONE;
                            if (pat_q != PAT_ALARM) tones_d = tones_q - 2'd1;
                        end else if (pat_q == PAT_ALARM || tones_q != 2'd0) begin
                            state_d = ST_GAP;
                        end else begin
                            fin = 1'b1;
                        end
                    end else if (tick) begin
                        unit_d = unit_q + UW'(1);
                    end
                end
                ST_SEP: begin
                    if (seg_end) begin
                        state_d = ST_TONE;
                        restart = 1'b1;
                        unit_d  = '0;
                        if (pend_d[1]) begin
                            pat_d     = PAT_DONE;
                            pend_d[1] = 1'b0;
                        end else begin
                            pat_d     = PAT_PHASE;
                            pend_d[0] = 1'b0;
                        end
                        tones_d = tone_count(pat_d) - 2'd1;
                    end else if (tick) begin
                        unit_d = unit_q + UW'(1);
                    end
                end
                default: ;
            endcase
            if (fin) begin
                restart = 1'b1;
                unit_d  = '0;
                pat_d   = PAT_NONE;
                state_d = (pend_d != 2'b00) ? ST_SEP : ST_IDLE;
            end
        end

        beep_d = (state_d == ST_TONE) && !(mute && pat_d != PAT_ALARM);
    end

    always_ff @(posedge cp) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_NONE;
            pend_q  <= '0;
            tones_q <= '0;
            unit_q  <= '0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            pend_q  <= pend_d;
            tones_q <= tones_d;
            unit_q  <= unit_d;
            beep_q  <= beep_d;
        end
    end

    assign beep    = beep_q;
    assign busy    = (state_q != ST_IDLE);
    assign pattern = pat_q;

endmodule
